// File: rtl/logic_op_sequencer_pkg.sv
// Shared definitions for the logic-op sequencer slice.
//   op_t    : operation encodings carried to the combinational logic unit
//   state_t : sequencer FSM states, also exported on the state_dbg port
package logic_op_sequencer_pkg;

  localparam int OP_W = 2;

  typedef enum logic [OP_W-1:0] {
    OP_AND = 2'b00,
    OP_OR  = 2'b01,
    OP_XOR = 2'b10,
    OP_NOT = 2'b11
  } op_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_HOLD  = 2'd2
  } state_t;

endpackage

// File: rtl/logic_op_sequencer_if.sv
// Command / result handshake bundle of the logic-op sequencer.
//   cmd_valid/cmd_ready/cmd_op/cmd_a/cmd_b : request channel (initiator -> sequencer)
//   res_valid/res_ready/res_data           : result channel (sequencer -> consumer)
// Handshake: a transfer happens on a rising clk edge where valid and ready are both 1.
// Once raised, valid stays high and the payload stays stable until that transfer;
// ready may change freely and never depends combinationally on valid.
interface logic_op_sequencer_if #(
  parameter int W = 16
);
  import logic_op_sequencer_pkg::*;

  logic            cmd_valid;
  logic            cmd_ready;
  logic [OP_W-1:0] cmd_op;
  logic [W-1:0]    cmd_a;
  logic [W-1:0]    cmd_b;
  logic            res_valid;
  logic            res_ready;
  logic [W-1:0]    res_data;

  modport master (
    output cmd_valid, cmd_op, cmd_a, cmd_b, res_ready,
    input  cmd_ready, res_valid, res_data
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_a, cmd_b, res_ready,
    output cmd_ready, res_valid, res_data
  );

endinterface

// File: rtl/logic_op_sequencer_sync_fifo.sv
// Synchronous FIFO holding queued {op, a, b} commands.
//   clk, rst    : clock, synchronous active-high reset (empties the FIFO)
//   push, wdata : write an entry (caller guarantees !full)
//   pop, rdata  : rdata shows the head combinationally; pop drops it (caller guarantees !empty)
//   full, empty : occupancy flags
// Pointers carry one extra wrap bit so full and empty are distinguishable.
module logic_op_sequencer_sync_fifo #(
  parameter int WIDTH = 34,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  // Storage needs no reset: nothing is read while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= wdata;
  end

  assign rdata = mem[rd_ptr[AW-1:0]];
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

endmodule

// File: rtl/logic_op_sequencer.sv
// Logic-op sequencer: queues (op, a, b) requests, drives them one at a time onto a
// purely combinational logic unit, waits LAT extra settle cycles, captures lu_y and
// offers it on the result handshake.
//   clk, rst        : single clock, synchronous active-high reset
//   bus (slave)     : command and result handshakes (see logic_op_sequencer_if)
//   lu_op/lu_a/lu_b : registered operands to the logic unit, hold last issued values
//   lu_y            : combinational result from the logic unit
//   busy            : FSM not idle or commands still queued
//   state_dbg       : current FSM state
module logic_op_sequencer
  import logic_op_sequencer_pkg::*;
#(
  parameter int W     = 16,
  parameter int DEPTH = 4,
  parameter int LAT   = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  logic_op_sequencer_if.slave   bus,
  output logic [OP_W-1:0]       lu_op,
  output logic [W-1:0]          lu_a,
  output logic [W-1:0]          lu_b,
  input  logic [W-1:0]          lu_y,
  output logic                  busy,
  output state_t                state_dbg
);
  localparam int          FW    = 2*W + OP_W;
  localparam logic [3:0]  LAT_C = 4'(LAT);

  state_t        state, state_nxt;
  logic [3:0]    cnt;
  logic          push, pop, full, empty;
  logic [FW-1:0] head;
  logic          load, capture, release_res;
  logic          res_valid_q;
  logic [W-1:0]  res_data_q;

  // Acceptance depends only on FIFO space, never on cmd_valid.
  assign bus.cmd_ready = !full;
  assign push          = bus.cmd_valid && !full;
  assign pop           = load;

  logic_op_sequencer_sync_fifo #(
    .WIDTH (FW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .wdata ({bus.cmd_op, bus.cmd_a, bus.cmd_b}),
    .pop   (pop),
    .rdata (head),
    .full  (full),
    .empty (empty)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (!empty) state_nxt = ST_ISSUE;
      ST_ISSUE: if (cnt == LAT_C) state_nxt = ST_HOLD;
      ST_HOLD:  if (bus.res_ready) state_nxt = empty ? ST_IDLE : ST_ISSUE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // Control outputs: load pops the head into lu_*, capture latches lu_y,
  // release_res completes the result handshake.
  always_comb begin
    load        = 1'b0;
    capture     = 1'b0;
    release_res = 1'b0;
    case (state)
      ST_IDLE:  load = !empty;
      ST_ISSUE: capture = (cnt == LAT_C);
      ST_HOLD: begin
        release_res = bus.res_ready;
        load        = bus.res_ready && !empty;   // back-to-back issue
      end
      default: ;
    endcase
  end

  // Datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt         <= '0;
      lu_op       <= '0;
      lu_a        <= '0;
      lu_b        <= '0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
    end else begin
      if (load) begin
        {lu_op, lu_a, lu_b} <= head;
        cnt                 <= '0;
      end else if (state == ST_ISSUE && !capture) begin
        cnt <= cnt + 4'd1;
      end
      if (capture) begin
        res_valid_q <= 1'b1;
        res_data_q  <= lu_y;
      end else if (release_res) begin
        res_valid_q <= 1'b0;
      end
    end
  end

  assign bus.res_valid = res_valid_q;
  assign bus.res_data  = res_data_q;
  assign busy          = (state != ST_IDLE) || !empty;
  assign state_dbg     = state;

endmodule

// File: tb/tb_logic_op_sequencer.sv
// Bench for logic_op_sequencer: one LAT=0 instance (dut0) and one LAT=2 instance
// (dut2), each with a behavioural logic unit. Inputs change 1 time unit after a
// rising edge; outputs and handshakes are sampled on the falling edge.
module tb_logic_op_sequencer;
  import logic_op_sequencer_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  // ---------------- DUTs ----------------
  logic_op_sequencer_if #(.W(16)) bus0 ();
  logic_op_sequencer_if #(.W(16)) bus2 ();

  logic [1:0]  lu_op0, lu_op2;
  logic [15:0] lu_a0, lu_b0, lu_y0, lu_a2, lu_b2, lu_y2;
  logic        busy0, busy2;
  state_t      state0, state2;

  function automatic logic [15:0] lu_fn(input logic [1:0] op, input logic [15:0] a,
                                        input logic [15:0] b);
    case (op)
      2'b00:   return a & b;
      2'b01:   return a | b;
      2'b10:   return a ^ b;
      default: return ~a;
    endcase
  endfunction

  assign lu_y0 = lu_fn(lu_op0, lu_a0, lu_b0);
  assign lu_y2 = lu_fn(lu_op2, lu_a2, lu_b2);

  logic_op_sequencer #(.W(16), .DEPTH(4), .LAT(0)) dut0 (
    .clk(clk), .rst(rst), .bus(bus0.slave), .lu_op(lu_op0), .lu_a(lu_a0), .lu_b(lu_b0),
    .lu_y(lu_y0), .busy(busy0), .state_dbg(state0)
  );

  logic_op_sequencer #(.W(16), .DEPTH(4), .LAT(2)) dut2 (
    .clk(clk), .rst(rst), .bus(bus2.slave), .lu_op(lu_op2), .lu_a(lu_a2), .lu_b(lu_b2),
    .lu_y(lu_y2), .busy(busy2), .state_dbg(state2)
  );

  // ---------------- scoreboard ----------------
  int checks   = 0;
  int failures = 0;
  logic [15:0] exp_q[$];
  logic [15:0] exp2_q[$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  logic [15:0] e0, e2;
  bit gap_en  = 1'b0;
  int last_hs = -1;
  bit saw_valid2 = 1'b0;

  always @(negedge clk) begin
    if (!rst && bus0.res_valid && bus0.res_ready) begin
      if (exp_q.size() == 0) begin
        check_eq("res0_unexpected", 1, 0);
      end else begin
        e0 = exp_q.pop_front();
        check_eq("res0_data", 32'(bus0.res_data), 32'(e0));
      end
      if (gap_en && last_hs >= 0) check_eq("b2b_gap", cyc - last_hs, 2);
      last_hs = cyc;
    end
  end

  always @(negedge clk) begin
    if (!rst && bus2.res_valid) saw_valid2 = 1'b1;
    if (!rst && bus2.res_valid && bus2.res_ready) begin
      if (exp2_q.size() == 0) begin
        check_eq("res2_unexpected", 1, 0);
      end else begin
        e2 = exp2_q.pop_front();
        check_eq("res2_data", 32'(bus2.res_data), 32'(e2));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Call 1 time unit after a rising edge; returns 1 time unit after the accepting edge.
  task automatic push_cmd(input int sel, input logic [1:0] op, input logic [15:0] a,
                          input logic [15:0] b);
    int   n;
    logic rdy;
    n   = 0;
    rdy = 1'b0;
    if (sel == 0) begin
      bus0.cmd_valid = 1'b1; bus0.cmd_op = op; bus0.cmd_a = a; bus0.cmd_b = b;
    end else begin
      bus2.cmd_valid = 1'b1; bus2.cmd_op = op; bus2.cmd_a = a; bus2.cmd_b = b;
    end
    while (!rdy && n < 200) begin
      @(negedge clk);
      rdy = (sel == 0) ? bus0.cmd_ready : bus2.cmd_ready;
      @(posedge clk);
      n++;
    end
    check_eq("push_accept", 32'(rdy), 1);
    if (rdy) begin
      if (sel == 0) exp_q.push_back(lu_fn(op, a, b));
      else          exp2_q.push_back(lu_fn(op, a, b));
    end
    #1;
    if (sel == 0) bus0.cmd_valid = 1'b0;
    else          bus2.cmd_valid = 1'b0;
  endtask

  task automatic wait_drain(input int sel, input int budget);
    int   n;
    logic done;
    n    = 0;
    done = 1'b0;
    while (!done && n < budget) begin
      @(negedge clk);
      done = (sel == 0) ? (exp_q.size() == 0 && !busy0) : (exp2_q.size() == 0 && !busy2);
      n++;
    end
    check_eq((sel == 0) ? "drain0" : "drain2", 32'(done), 1);
    step();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    bus0.cmd_valid = 1'b0; bus0.cmd_op = 2'b00; bus0.cmd_a = '0; bus0.cmd_b = '0;
    bus0.res_ready = 1'b0;
    bus2.cmd_valid = 1'b0; bus2.cmd_op = 2'b00; bus2.cmd_a = '0; bus2.cmd_b = '0;
    bus2.res_ready = 1'b0;

    // Reset: two edges with rst high
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_eq("rst_res_valid", 32'(bus0.res_valid), 0);
    check_eq("rst_cmd_ready", 32'(bus0.cmd_ready), 1);
    check_eq("rst_busy",      32'(busy0), 0);
    check_eq("rst_lu_a",      32'(lu_a0), 0);
    check_eq("rst_lu_b",      32'(lu_b0), 0);
    check_eq("rst_lu_op",     32'(lu_op0), 0);
    check_eq("rst_res_data",  32'(bus0.res_data), 0);
    check_eq("rst_state",     32'(state0), 32'(ST_IDLE));
    check_eq("rst2_cmd_ready", 32'(bus2.cmd_ready), 1);
    step();

    // Single AND, LAT=0: accept E0, pop E1, res_valid after E2
    push_cmd(0, OP_AND, 16'h00FF, 16'h0F0F);
    @(negedge clk);
    check_eq("and_valid_e0", 32'(bus0.res_valid), 0);
    check_eq("and_busy_e0",  32'(busy0), 1);
    @(negedge clk);
    check_eq("and_valid_e1", 32'(bus0.res_valid), 0);
    check_eq("and_lu_a",     32'(lu_a0), 'h00FF);
    check_eq("and_state_e1", 32'(state0), 32'(ST_ISSUE));
    @(negedge clk);
    check_eq("and_valid_e2", 32'(bus0.res_valid), 1);
    check_eq("and_data",     32'(bus0.res_data), 'h000F);
    step();
    bus0.res_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check_eq("and_valid_done", 32'(bus0.res_valid), 0);
    check_eq("and_busy_done",  32'(busy0), 0);
    check_eq("and_lu_hold",    32'(lu_b0), 'h0F0F);
    step();

    // Backpressure: five accepted with res_ready low, then full
    bus0.res_ready = 1'b0;
    push_cmd(0, OP_OR,  16'hF000, 16'h000F);
    push_cmd(0, OP_XOR, 16'hAAAA, 16'h5555);
    push_cmd(0, OP_NOT, 16'h00FF, 16'h1234);
    push_cmd(0, OP_AND, 16'hFFFF, 16'h1234);
    push_cmd(0, OP_OR,  16'h0F00, 16'h00F0);
    @(negedge clk);
    check_eq("bp_cmd_ready_full", 32'(bus0.cmd_ready), 0);
    check_eq("bp_res_valid",      32'(bus0.res_valid), 1);
    check_eq("bp_first_data",     32'(bus0.res_data), 'hF00F);
    step();
    bus0.cmd_valid = 1'b1;   // 6th request held off while full
    @(negedge clk);
    check_eq("bp_cmd_ready_6th", 32'(bus0.cmd_ready), 0);
    step();
    bus0.cmd_valid = 1'b0;
    gap_en  = 1'b1;
    last_hs = -1;
    bus0.res_ready = 1'b1;
    wait_drain(0, 60);

    // Back-to-back XORs, one result every two cycles
    bus0.res_ready = 1'b0;
    push_cmd(0, OP_XOR, 16'hFFFF, 16'h00FF);
    push_cmd(0, OP_XOR, 16'h1234, 16'hFFFF);
    push_cmd(0, OP_XOR, 16'h0000, 16'hC3C3);
    @(negedge clk);
    check_eq("b2b_first_data", 32'(bus0.res_data), 'hFF00);
    step();
    last_hs = -1;
    bus0.res_ready = 1'b1;
    wait_drain(0, 40);
    gap_en = 1'b0;

    // Random traffic with random result backpressure
    fork
      begin
        for (int i = 0; i < 24; i++) begin
          push_cmd(0, 2'($urandom_range(0, 3)), 16'($urandom), 16'($urandom));
          repeat ($urandom_range(0, 2)) step();
        end
      end
      begin
        for (int k = 0; k < 100; k++) begin
          bus0.res_ready = 1'($urandom_range(0, 1));
          step();
        end
        bus0.res_ready = 1'b1;
      end
    join
    bus0.res_ready = 1'b1;
    wait_drain(0, 200);

    // LAT=2: single NOT, res_valid only after E4
    bus2.res_ready = 1'b0;
    push_cmd(2, OP_NOT, 16'h1234, 16'h0000);
    repeat (4) @(negedge clk);
    check_eq("lat2_valid_e3", 32'(bus2.res_valid), 0);
    @(negedge clk);
    check_eq("lat2_valid_e4", 32'(bus2.res_valid), 1);
    check_eq("lat2_data",     32'(bus2.res_data), 'hEDCB);
    step();
    bus2.res_ready = 1'b1;
    wait_drain(2, 20);

    // Reset during ISSUE discards queued and in-flight commands
    bus2.res_ready = 1'b0;
    push_cmd(2, OP_AND, 16'h1111, 16'h2222);
    push_cmd(2, OP_OR,  16'h3333, 16'h4444);
    push_cmd(2, OP_XOR, 16'h5555, 16'h6666);
    @(negedge clk);
    check_eq("mid_state_issue", 32'(state2), 32'(ST_ISSUE));
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    exp2_q.delete();
    saw_valid2 = 1'b0;
    bus2.res_ready = 1'b1;
    repeat (10) @(negedge clk);
    check_eq("mid_no_result", 32'(saw_valid2), 0);
    check_eq("mid_busy",      32'(busy2), 0);
    check_eq("mid_cmd_ready", 32'(bus2.cmd_ready), 1);
    check_eq("mid_state",     32'(state2), 32'(ST_IDLE));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Watchdog
  initial begin
    #1000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog expired");
  end

endmodule
